// File: rtl/txeth_mii.sv
// txeth_mii -- MII transmit engine for one Ethernet frame held in txbuf.
//
// A one-cycle start_i in IDLE latches len_i and sends: 16 preamble/SFD
// nibbles, len bytes read from txbuf (low byte of each 16-bit word first,
// low nibble first), zero padding up to MINLEN bytes, optionally the FCS,
// then IFG_NIB idle nibble clocks, ending with a one-cycle done_o pulse.
//
// Optional feature macro: ETH_TXCRC_EN -- when defined the block appends a
// CRC-32 FCS (8 nibbles); when undefined the host supplies the FCS in txbuf.
//
// Ports:
//   eth_clk_i   MII TX clock (only clock)
//   eth_rstn_i  synchronous active-low reset
//   start_i     one-cycle transmit request (honoured only in IDLE)
//   len_i       frame byte count excluding FCS
//   eth_adr_o   txbuf word address (read data returns one clock later)
//   eth_dat_i   txbuf read data
//   mii_txd_o   MII transmit nibble
//   mii_txen_o  MII transmit enable
//   busy_o      high while a frame or its inter-frame gap is in progress
//   done_o      one-cycle pulse on the last IFG clock
module txeth_mii #(
    parameter int MINLEN  = 60,
    parameter int IFG_NIB = 24
) (
    input  logic        eth_clk_i,
    input  logic        eth_rstn_i,
    input  logic        start_i,
    input  logic [10:0] len_i,
    output logic [9:0]  eth_adr_o,
    input  logic [15:0] eth_dat_i,
    output logic [3:0]  mii_txd_o,
    output logic        mii_txen_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAD,
`ifdef ETH_TXCRC_EN
        CRC,
`endif
        IFG
    } state_t;

    localparam logic [15:0] MIN_NIB  = 16'(2 * MINLEN);
    localparam logic [15:0] IFG_LAST = 16'(IFG_NIB - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;       // nibble index within the current state
    logic [10:0] len_q, len_n;
    logic [9:0]  adr_n;
    logic [3:0]  txd_n;
    logic        txen_n, busy_n, done_n;
    logic        pay_go;           // next nibble belongs to the DATA/PAD payload
    logic [15:0] pay_idx;          // payload nibble index of the next nibble
    logic [15:0] nib_tot;          // 2*len: payload nibbles that come from txbuf
    logic        to_ifg;

`ifdef ETH_TXCRC_EN
    logic [31:0] crc, crc_n;

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    function automatic logic [3:0] sel_nib(input logic [15:0] w, input logic [1:0] k);
        return 4'(w >> {k, 2'b00});
    endfunction

    assign nib_tot = {4'b0000, len_q, 1'b0};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len_q;
        adr_n   = eth_adr_o;
        txd_n   = '0;
        txen_n  = 1'b0;
        done_n  = 1'b0;
        pay_go  = 1'b0;
        pay_idx = cnt + 16'd1;
        to_ifg  = 1'b0;
`ifdef ETH_TXCRC_EN
        crc_n   = crc;
`endif
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = PRE;
                    cnt_n   = '0;
                    len_n   = len_i;
                    adr_n   = '0;
                    txd_n   = 4'h5;
                    txen_n  = 1'b1;
`ifdef ETH_TXCRC_EN
                    crc_n   = '1;
`endif
                end
            end
            PRE: begin
                if (cnt == 16'd15) begin
                    pay_go  = 1'b1;
                    pay_idx = '0;
                end else begin
                    cnt_n  = cnt + 16'd1;
                    txen_n = 1'b1;
                    txd_n  = (cnt == 16'd14) ? 4'hD : 4'h5;
                end
            end
            DATA, PAD: pay_go = 1'b1;
`ifdef ETH_TXCRC_EN
            CRC: begin
                if (cnt == 16'd7) begin
                    to_ifg = 1'b1;
                end else begin
                    cnt_n  = cnt + 16'd1;
                    txen_n = 1'b1;
                    txd_n  = ~crc[3:0];
                    crc_n  = {4'h0, crc[31:4]};
                end
            end
`endif
            IFG: begin
                if (cnt == IFG_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n  = cnt + 16'd1;
                    done_n = (cnt + 16'd1 == IFG_LAST);
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so each nibble is chosen one edge ahead.
        // Read data lags the address by a clock, so the next word address is
        // issued while nibble 2 of the current word is registered; it is not
        // advanced past the last word the frame needs.
        if (pay_go) begin
            cnt_n = pay_idx;
            if (pay_idx < nib_tot) begin
                state_n = DATA;
                txen_n  = 1'b1;
                txd_n   = sel_nib(eth_dat_i, pay_idx[1:0]);
                if (pay_idx[1:0] == 2'd2 && (pay_idx + 16'd2) < nib_tot)
                    adr_n = eth_adr_o + 10'd1;
`ifdef ETH_TXCRC_EN
                crc_n = crc_nib(crc, txd_n);
`endif
            end else if (pay_idx < MIN_NIB) begin
                state_n = PAD;
                txen_n  = 1'b1;
                txd_n   = 4'h0;
`ifdef ETH_TXCRC_EN
                crc_n   = crc_nib(crc, 4'h0);
`endif
            end else begin
`ifdef ETH_TXCRC_EN
                state_n = CRC;
                cnt_n   = '0;
                txen_n  = 1'b1;
                txd_n   = ~crc[3:0];
                crc_n   = {4'h0, crc[31:4]};
`else
                to_ifg  = 1'b1;
`endif
            end
        end

        if (to_ifg) begin
            state_n = IFG;
            cnt_n   = '0;
            done_n  = (IFG_LAST == 16'd0);
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge eth_clk_i) begin
        if (!eth_rstn_i) begin
            state      <= IDLE;
            cnt        <= '0;
            len_q      <= '0;
            eth_adr_o  <= '0;
            mii_txd_o  <= '0;
            mii_txen_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
`ifdef ETH_TXCRC_EN
            crc        <= '0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            len_q      <= len_n;
            eth_adr_o  <= adr_n;
            mii_txd_o  <= txd_n;
            mii_txen_o <= txen_n;
            busy_o     <= busy_n;
            done_o     <= done_n;
`ifdef ETH_TXCRC_EN
            crc        <= crc_n;
`endif
        end
    end

endmodule

// File: doc/txeth_mii.md
TXETH_MII -- requirements
Module: txeth_mii

Interface
REQ-001 SHALL have parameter MINLEN, default 60: minimum frame byte count before FCS; shorter frames are zero-padded.
REQ-002 SHALL have parameter IFG_NIB, default 24: inter-frame gap in nibble clocks (96 bit times).
REQ-003 SHALL have port eth_clk_i, input, 1 bit: MII TX clock; the only clock.
REQ-004 SHALL have port eth_rstn_i, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start_i, input, 1 bit: one-cycle transmit request.
REQ-006 SHALL have port len_i, input, 11 bits: frame byte count from txbuf word 0, excluding FCS.
REQ-007 SHALL have port eth_adr_o, output, 10 bits: txbuf Ethernet-side word address.
REQ-008 SHALL have port eth_dat_i, input, 16 bits: txbuf read data; valid one eth_clk_i after eth_adr_o.
REQ-009 SHALL have port mii_txd_o, output, 4 bits: MII transmit nibble.
REQ-010 SHALL have port mii_txen_o, output, 1 bit: MII transmit enable.
REQ-011 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port done_o, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement the states IDLE, PRE, DATA, PAD, CRC and IFG; all outputs are registered.
REQ-014 SHALL sample start_i only in IDLE, latching len_i and moving to PRE; start_i in any other state SHALL be ignored.
REQ-015 SHALL drive mii_txen_o high in the cycle after start_i is accepted, with the first preamble nibble on mii_txd_o.
REQ-016 SHALL send 15 nibbles of 0x5 followed by one nibble of 0xD in PRE, then move to DATA.
REQ-017 SHALL send bytes in DATA low nibble first, using eth_dat_i[7:0] then eth_dat_i[15:8] of each word; the byte index runs 0..len-1 and eth_adr_o equals the byte index divided by 2.
REQ-018 SHALL prefetch: eth_adr_o is 0 from acceptance, and the next word address is presented at least one cycle before its first nibble, so no stall nibbles occur.
REQ-019 SHALL ignore the high byte of the last word when len is odd.
REQ-020 SHALL, when len < MINLEN, send 2*(MINLEN-len) nibbles of 0x0 in PAD; len = 0 gives MINLEN pad bytes.
REQ-021 SHALL keep mii_txen_o high continuously from the first preamble nibble through the last frame nibble.
REQ-022 SHALL, in IFG, drive mii_txen_o = 0 and mii_txd_o = 0 for IFG_NIB cycles.
REQ-023 SHALL, on the last IFG cycle, pulse done_o for 1 cycle and return to IDLE; busy_o falls in the same cycle.
REQ-024 SHALL keep eth_adr_o within 0..1023; len 2047 reads words 0..1023 with no wrap.

Reset
REQ-025 SHALL, when eth_rstn_i = 0 at a rising edge, set state = IDLE, mii_txen_o = 0, mii_txd_o = 0, eth_adr_o = 0, busy_o = 0, done_o = 0, and clear all counters and the CRC register.
REQ-026 SHALL, on reset during a frame, truncate the frame at that edge without a done_o pulse; the next start_i after reset is accepted normally.

Configuration
REQ-027 SHALL, with ETH_TXCRC_EN defined, implement CRC-32 as follows:
- reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF;
- updated 4 bits per nibble over the DATA and PAD nibbles;
- CRC state follows PAD (or DATA when no padding), sending 8 nibbles, each ~crc[3:0], then shifting the CRC right by 4.
REQ-028 SHALL, without ETH_TXCRC_EN, omit the CRC state and logic: the frame ends after DATA/PAD (host supplies the FCS in txbuf), and IFG follows directly.

Verification
REQ-029 With CRC enabled, len=64 (words 0x0100, 0x0302, ...), start_i pulsed: mii_txen_o high for exactly 152 cycles; nibbles 16..23 = 0,0,1,0,2,0,3,0; IFG 24 cycles, then done_o pulses once.
REQ-030 With CRC enabled, len=10: mii_txen_o high for 144 cycles; nibbles 36..135 all 0x0; a reflected CRC (init 0xFFFFFFFF) over nibbles 16..143 yields residue 0xDEBB20E3.
REQ-031 Without the macro, len=61: mii_txen_o high for 138 cycles; the last data nibble pair comes from eth_dat_i[7:0] of word 30; the high byte of word 30 is never sent.
REQ-032 With start_i re-pulsed at frame nibble 40 and again on the done_o cycle: both pulses are ignored, and no second frame starts until start_i is asserted in IDLE.
REQ-033 With eth_rstn_i low for 1 cycle at DATA nibble 50: mii_txen_o = 0 and busy_o = 0 on the next cycle, done_o never pulses, and a following start_i with len=60 transmits a complete 144-cycle frame.
